// File: rtl/fp_multiply_pipe.sv
// Three-stage signed fixed-point multiplier with selectable rounding, saturation or wrap,
// and an elastic stall. Also keeps a sticky overflow flag and a saturating overflow counter.
module fp_multiply_pipe #(
  parameter int WI1  = 4,
  parameter int WF1  = 5,
  parameter int WI2  = 4,
  parameter int WF2  = 5,
  parameter int WIO  = 4,
  parameter int WFO  = 4,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WI1+WF1-1:0]   A,
  input  logic [WI2+WF2-1:0]   B,
  input  logic                 rnd_mode,
  input  logic                 sat_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIO+WFO-1:0]   multiply,
  output logic                 overflow,
  output logic                 ovf_sticky,
  output logic [CNTW-1:0]      ovf_count,
  input  logic                 clr_ovf
);

  localparam int W1    = WI1 + WF1;
  localparam int W2    = WI2 + WF2;
  localparam int WP    = W1 + W2;
  localparam int INTL  = WI1 + WI2;
  localparam int FRACL = WF1 + WF2;
  localparam int WO    = WIO + WFO;
  localparam int QW    = INTL + WFO;

  logic                 en;
  logic                 v1, v2;
  logic signed [W1-1:0] a_q;
  logic signed [W2-1:0] b_q;
  logic                 rnd1, sat1, rnd2, sat2;
  logic signed [WP-1:0] p_q;
  logic signed [QW-1:0] q;
  logic [WO-1:0]        res_d;
  logic                 ovf_d;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // q: product aligned to the output fraction, still carrying all INTL integer bits
  generate
    if (WFO >= FRACL) begin : g_pad
      assign q = QW'(p_q) <<< (WFO - FRACL);
    end else begin : g_rnd
      localparam int D = FRACL - WFO;
      logic signed [WP:0] sum;
      always_comb begin
        sum = {p_q[WP-1], p_q};
        if (rnd2) sum = sum + ((WP+1)'(1) << (D - 1));
      end
      // rounding cannot exceed INTL integer bits, so the extra sum bit is redundant
      assign q = QW'(sum >>> D);
    end
  endgenerate

  generate
    if (WIO >= INTL) begin : g_ext
      assign res_d = WO'(q);
      assign ovf_d = 1'b0;
    end else begin : g_red
      localparam int UW = INTL - WIO + 1;
      logic [UW-1:0] upper;
      logic [WO-1:0] lo, maxv, minv;
      always_comb begin
        upper = q[QW-1 -: UW];
        lo    = q[WO-1:0];
        ovf_d = q[QW-1] ? ~&upper : |upper;
        maxv  = '1;
        maxv[WO-1] = 1'b0;
        minv  = '0;
        minv[WO-1] = 1'b1;
        res_d = lo;
        if (ovf_d) begin
          res_d[WO-1] = q[QW-1];
          if (sat2) res_d = q[QW-1] ? minv : maxv;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rnd1      <= 1'b0;
      sat1      <= 1'b0;
      p_q       <= '0;
      rnd2      <= 1'b0;
      sat2      <= 1'b0;
      multiply  <= '0;
      overflow  <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      a_q       <= A;
      b_q       <= B;
      rnd1      <= rnd_mode;
      sat1      <= sat_en;
      v2        <= v1;
      p_q       <= a_q * b_q;
      rnd2      <= rnd1;
      sat2      <= sat1;
      out_valid <= v2;
      multiply  <= res_d;
      overflow  <= v2 && ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (clr_ovf) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (out_valid && out_ready && overflow) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != '1) ovf_count <= ovf_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_fp_multiply_pipe.sv
// Directed bench for fp_multiply_pipe at default widths (Q4.5 x Q4.5 -> Q4.4).
module tb_fp_multiply_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [8:0]  A, B;
  logic        rnd_mode, sat_en;
  logic        out_valid, out_ready;
  logic [7:0]  multiply;
  logic        overflow, ovf_sticky, clr_ovf;
  logic [15:0] ovf_count;

  int nvec = 0;
  int nmis = 0;

  fp_multiply_pipe #(.WI1(4), .WF1(5), .WI2(4), .WF2(5), .WIO(4), .WFO(4), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .rnd_mode(rnd_mode), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready), .multiply(multiply),
    .overflow(overflow), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // single transaction with out_ready held high; ends after the handshake edge
  task automatic run1(input string tag, input logic [8:0] a, input logic [8:0] b,
                      input logic rnd, input logic sat, input logic [7:0] em, input logic eo);
    A = a; B = b; rnd_mode = rnd; sat_en = sat; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_mul"}, 32'(multiply), 32'(em));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    step();
  endtask

  logic [8:0] sa [5] = '{9'h020, 9'h040, 9'h060, 9'h080, 9'h0A0};
  logic [7:0] se [5] = '{8'hF0, 8'hE0, 8'hD0, 8'hC0, 8'hB0};

  initial begin
    int idx, outidx;
    logic acc, seen;
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; rnd_mode = 1'b0; sat_en = 1'b0;
    out_ready = 1'b1; clr_ovf = 1'b0;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_mul", 32'(multiply), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_cnt", 32'(ovf_count), 32'd0);
    check("rst_sticky", 32'(ovf_sticky), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // latency: out_valid on the third edge counting the accepting one
    A = 9'h030; B = 9'h040; rnd_mode = 1'b0; sat_en = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_e1", 32'(out_valid), 32'd0);
    step();
    check("lat_e2", 32'(out_valid), 32'd0);
    step();
    check("lat_e3", 32'(out_valid), 32'd1);
    check("lat_mul", 32'(multiply), 32'h30);
    check("lat_ovf", 32'(overflow), 32'd0);
    step();
    check("lat_drain", 32'(out_valid), 32'd0);

    run1("sq7_sat", 9'h0E0, 9'h0E0, 1'b0, 1'b1, 8'h7F, 1'b1);
    run1("sq7_wrap", 9'h0E0, 9'h0E0, 1'b0, 1'b0, 8'h10, 1'b1);
    check("cnt_2", 32'(ovf_count), 32'd2);
    check("sticky_1", 32'(ovf_sticky), 32'd1);

    run1("lsb_trunc", 9'h001, 9'h020, 1'b0, 1'b0, 8'h00, 1'b0);
    run1("lsb_round", 9'h001, 9'h020, 1'b1, 1'b0, 8'h01, 1'b0);
    run1("neg_trunc", 9'h1FF, 9'h020, 1'b0, 1'b0, 8'hFF, 1'b0);
    run1("neg_round", 9'h1FF, 9'h020, 1'b1, 1'b0, 8'h00, 1'b0);
    run1("half_round", 9'h003, 9'h010, 1'b1, 1'b0, 8'h01, 1'b0);
    run1("neg_mul", 9'h1D0, 9'h040, 1'b0, 1'b0, 8'hD0, 1'b0);
    run1("min_exact", 9'h100, 9'h020, 1'b0, 1'b1, 8'h80, 1'b0);
    run1("neg_wrap", 9'h100, 9'h030, 1'b0, 1'b0, 8'hC0, 1'b1);
    run1("neg_sat", 9'h100, 9'h030, 1'b0, 1'b1, 8'h80, 1'b1);
    check("cnt_4", 32'(ovf_count), 32'd4);

    // stall: five back-to-back offers with out_ready low, then drain
    B = 9'h1E0; rnd_mode = 1'b0; sat_en = 1'b0;
    out_ready = 1'b0; idx = 0; outidx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 5);
      A = (idx < 5) ? sa[idx] : '0;
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    check("stall_accepts", 32'(idx), 32'd3);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_hold", 32'(multiply), 32'(se[0]));
      step();
    end
    out_ready = 1'b1;
    #1;
    for (int c = 0; c < 20 && outidx < 5; c++) begin
      if (out_valid) begin
        check("stream_out", 32'(multiply), 32'(se[outidx]));
        outidx++;
      end
      in_valid = (idx < 5);
      A = (idx < 5) ? sa[idx] : '0;
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("stream_count", 32'(outidx), 32'd5);
    step();
    check("stream_tail", 32'(out_valid), 32'd0);

    // clear wins over a coincident overflow handshake
    check("pre_clr_cnt", 32'(ovf_count), 32'd4);
    A = 9'h0E0; B = 9'h0E0; sat_en = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("clr_ovf_present", 32'(overflow && out_valid), 32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("clr_cnt", 32'(ovf_count), 32'd0);
    check("clr_sticky", 32'(ovf_sticky), 32'd0);

    // reset with three results in flight
    run1("pre_rst", 9'h0E0, 9'h0E0, 1'b0, 1'b1, 8'h7F, 1'b1);
    check("pre_rst_cnt", 32'(ovf_count), 32'd1);
    out_ready = 1'b0;
    A = 9'h0E0; B = 9'h0E0; in_valid = 1'b1;
    step(); step(); step();
    in_valid = 1'b0;
    check("inflight_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_mul", 32'(multiply), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_cnt", 32'(ovf_count), 32'd0);
    check("mid_rst_sticky", 32'(ovf_sticky), 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("no_stale", 32'(seen), 32'd0);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
